// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Shares the single regbank write port between N_REQ execution pipes.
// Each pipe hands over a result (physical rd + data) through a valid/ready
// handshake into its own 1-entry holding register. Every cycle, one full
// holding entry is granted round-robin and drives the regbank write port.
//
// Optional feature: define WB_ARB_PERF_EN to add the 32-bit saturating
// conflict_count output. It counts cycles in which at least two holding
// entries are full, meaning one is written while another waits.

module writeback_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][AWIDTH-1:0]   req_addr,
    input  logic [N_REQ-1:0][DWIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           write_valid,
    output logic [AWIDTH-1:0]              write_address,
    output logic [DWIDTH-1:0]              write_data,
    output logic [$clog2(N_REQ)-1:0]       grant_id
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                    conflict_count
`endif
);

    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]               hold_full;
    logic [N_REQ-1:0][AWIDTH-1:0]   hold_addr;
    logic [N_REQ-1:0][DWIDTH-1:0]   hold_data;
    logic [IDW-1:0]                 rr_ptr;

    logic                           grant_valid;
    logic [IDW-1:0]                 grant_sel;
    logic [IDW-1:0]                 scan_idx;
    logic [N_REQ-1:0]               grant_onehot;
    logic [N_REQ-1:0]               accept;
    logic [IDW-1:0]                 rr_next;

    // Round-robin scan of the holding entries only, starting at rr_ptr.
    // The grant never looks at req_valid, which keeps it off the requesters' timing paths.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_valid && hold_full[scan_idx]) begin
                grant_valid = 1'b1;
                grant_sel   = scan_idx;
            end
        end
    end

    // An entry is ready when it is empty or being drained this cycle.
    // This lets a requester refill its granted entry back to back.
    always_comb begin
        grant_onehot = '0;
        req_ready    = '0;
        accept       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_onehot[i] = grant_valid && (grant_sel == IDW'(i));
            req_ready[i]    = !hold_full[i] || grant_onehot[i];
            accept[i]       = req_valid[i] && req_ready[i];
        end
    end

    // Regbank write port: a mux of the granted entry, forced to zero when idle.
    always_comb begin
        write_valid   = grant_valid;
        write_address = '0;
        write_data    = '0;
        grant_id      = '0;
        if (grant_valid) begin
            write_address = hold_addr[grant_sel];
            write_data    = hold_data[grant_sel];
            grant_id      = grant_sel;
        end
    end

    // Pointer moves just past the entry written this cycle so every full entry waits at most N_REQ-1 cycles.
    always_comb begin
        rr_next = rr_ptr;
        if (grant_valid) begin
            rr_next = (grant_sel == IDW'(N_REQ - 1)) ? '0 : grant_sel + IDW'(1);
        end
    end

    // Occupancy flags and round-robin pointer. A write to register 0 is accepted but never stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i] && (req_addr[i] != '0)) begin
                    hold_full[i] <= 1'b1;
                end else if (grant_onehot[i]) begin
                    hold_full[i] <= 1'b0;
                end
            end
            rr_ptr <= rr_next;
        end
    end

    // Payload capture. It is qualified by hold_full on the way out, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i] && (req_addr[i] != '0)) begin
                hold_addr[i] <= req_addr[i];
                hold_data[i] <= req_data[i];
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic multi_full;

    // Two or more bits set: clearing the lowest set bit still leaves something.
    always_comb begin
        multi_full = (hold_full & (hold_full - N_REQ'(1))) != '0;
    end

    // Saturating count of cycles where a full entry had to wait behind the granted one.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (multi_full && (conflict_count != 32'hFFFF_FFFF)) begin
            conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
// Directed scenarios for writeback_arbiter (N_REQ=2, DWIDTH=32, AWIDTH=7).
// Inputs are driven and outputs sampled 1ns after each rising clk edge.
// If WB_ARB_PERF_EN is defined, this bench also checks conflict_count.

module tb_writeback_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][6:0]  req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0]       req_ready;
    logic             write_valid;
    logic [6:0]       write_address;
    logic [31:0]      write_data;
    logic [0:0]       grant_id;
`ifdef WB_ARB_PERF_EN
    logic [31:0]      conflict_count;
`endif

    logic [40:0]      wr_obs;
    int               checks;
    int               failures;

    assign wr_obs = {write_valid, write_address, write_data, grant_id};

    writeback_arbiter #(.N_REQ(2), .DWIDTH(32), .AWIDTH(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .write_valid   (write_valid),
        .write_address (write_address),
        .write_data    (write_data),
        .grant_id      (grant_id)
`ifdef WB_ARB_PERF_EN
        ,
        .conflict_count(conflict_count)
`endif
    );

    // 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        req_valid   = 2'b11;
        req_addr[0] = 7'd1;
        req_addr[1] = 7'd2;
        req_data[0] = 32'h1111_1111;
        req_data[1] = 32'h2222_2222;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (wr_obs !== 41'd0 || req_ready !== 2'b11) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: got write=%h ready=%b, expected write=0 ready=11", c, wr_obs, req_ready);
            end
        end
        reset     = 1'b0;
        req_valid = 2'b00;
        step();
        checks++;
        if (wr_obs !== 41'd0 || req_ready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_no_capture: got write=%h ready=%b, expected write=0 ready=11", wr_obs, req_ready);
        end
    endtask

    task automatic test_single;
        req_valid   = 2'b01;
        req_addr[0] = 7'd5;
        req_data[0] = 32'hDEAD_BEEF;
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== {1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0} || req_ready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL single_write: got write=%h ready=%b, expected write=%h ready=11", wr_obs, req_ready, {1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0});
        end
        step();
        checks++;
        if (wr_obs !== 41'd0) begin
            failures++;
            $display("[TB] FAIL single_idle: got write=%h, expected 0", wr_obs);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0]  a;
        logic [31:0] d;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            a           = 7'(k);
            d           = 32'(k * 32'h11);
            req_valid   = 2'b01;
            req_addr[0] = a;
            req_data[0] = d;
            checks++;
            if (req_ready[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_ready k=%0d: got %b, expected 1", k, req_ready[0]);
            end
            step();
            checks++;
            if (wr_obs !== {1'b1, a, d, 1'b0}) begin
                failures++;
                $display("[TB] FAIL b2b_write k=%0d: got %h, expected %h", k, wr_obs, {1'b1, a, d, 1'b0});
            end
        end
        req_valid = 2'b00;
        step();
        checks++;
        if (wr_obs !== 41'd0) begin
            failures++;
            $display("[TB] FAIL b2b_idle: got %h, expected 0", wr_obs);
        end
    endtask

    task automatic test_collision;
        do_reset();
        req_valid   = 2'b11;
        req_addr[0] = 7'd10;
        req_addr[1] = 7'd11;
        req_data[0] = 32'h1;
        req_data[1] = 32'h2;
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== {1'b1, 7'd10, 32'h1, 1'b0} || req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL collision_first: got write=%h ready=%b, expected write=%h ready=01", wr_obs, req_ready, {1'b1, 7'd10, 32'h1, 1'b0});
        end
        step();
        checks++;
        if (wr_obs !== {1'b1, 7'd11, 32'h2, 1'b1} || req_ready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL collision_second: got write=%h ready=%b, expected write=%h ready=11", wr_obs, req_ready, {1'b1, 7'd11, 32'h2, 1'b1});
        end
        step();
        checks++;
        if (wr_obs !== 41'd0) begin
            failures++;
            $display("[TB] FAIL collision_idle: got %h, expected 0", wr_obs);
        end
`ifdef WB_ARB_PERF_EN
        checks++;
        if (conflict_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL collision_conflict_count: got %0d, expected 1", conflict_count);
        end
`endif
        // The pointer wrapped back to 0, so a fresh collision must start with entry 0.
        req_valid   = 2'b11;
        req_addr[0] = 7'd12;
        req_addr[1] = 7'd13;
        req_data[0] = 32'h3;
        req_data[1] = 32'h4;
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== {1'b1, 7'd12, 32'h3, 1'b0}) begin
            failures++;
            $display("[TB] FAIL collision_rr_wrap: got %h, expected %h", wr_obs, {1'b1, 7'd12, 32'h3, 1'b0});
        end
        step();
        checks++;
        if (wr_obs !== {1'b1, 7'd13, 32'h4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL collision_rr_second: got %h, expected %h", wr_obs, {1'b1, 7'd13, 32'h4, 1'b1});
        end
        step();
    endtask

    task automatic test_fairness;
        int          acc0;
        int          acc1;
        int          writes;
        logic [40:0] exp_w;
        do_reset();
        acc0        = 0;
        acc1        = 0;
        writes      = 0;
        req_valid   = 2'b11;
        req_addr[0] = 7'd20;
        req_addr[1] = 7'd21;
        req_data[0] = 32'hA0;
        req_data[1] = 32'hB1;
        for (int j = 0; j < 20; j++) begin
            if (req_valid[0] && req_ready[0]) acc0++;
            if (req_valid[1] && req_ready[1]) acc1++;
            step();
            if (write_valid) writes++;
            exp_w = (j % 2 == 0) ? {1'b1, 7'd20, 32'hA0, 1'b0} : {1'b1, 7'd21, 32'hB1, 1'b1};
            checks++;
            if (wr_obs !== exp_w) begin
                failures++;
                $display("[TB] FAIL fairness_grant j=%0d: got %h, expected %h", j, wr_obs, exp_w);
            end
        end
        req_valid = 2'b00;
        checks++;
        if (acc0 != 11 || acc1 != 10 || writes != 20) begin
            failures++;
            $display("[TB] FAIL fairness_counts: got acc0=%0d acc1=%0d writes=%0d, expected 11 10 20", acc0, acc1, writes);
        end
        step();
        checks++;
        if (wr_obs !== {1'b1, 7'd20, 32'hA0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL fairness_drain: got %h, expected %h", wr_obs, {1'b1, 7'd20, 32'hA0, 1'b0});
        end
        step();
        checks++;
        if (wr_obs !== 41'd0) begin
            failures++;
            $display("[TB] FAIL fairness_idle: got %h, expected 0", wr_obs);
        end
    endtask

    task automatic test_zero_reg;
        do_reset();
        req_valid   = 2'b10;
        req_addr[1] = 7'd0;
        req_data[1] = 32'hFFFF;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_reg_ready: got %b, expected 1", req_ready[1]);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== 41'd0 || req_ready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL zero_reg_dropped: got write=%h ready=%b, expected write=0 ready=11", wr_obs, req_ready);
        end
        req_valid   = 2'b10;
        req_addr[1] = 7'd3;
        req_data[1] = 32'h33;
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== {1'b1, 7'd3, 32'h33, 1'b1}) begin
            failures++;
            $display("[TB] FAIL zero_reg_next: got %h, expected %h", wr_obs, {1'b1, 7'd3, 32'h33, 1'b1});
        end
        step();
    endtask

    task automatic test_reset_midop;
        do_reset();
        req_valid   = 2'b11;
        req_addr[0] = 7'd40;
        req_addr[1] = 7'd41;
        req_data[0] = 32'h40;
        req_data[1] = 32'h41;
        step();
        req_valid = 2'b00;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (wr_obs !== 41'd0 || req_ready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL midop_reset_clear: got write=%h ready=%b, expected write=0 ready=11", wr_obs, req_ready);
        end
        step();
        checks++;
        if (wr_obs !== 41'd0) begin
            failures++;
            $display("[TB] FAIL midop_no_write: got %h, expected 0", wr_obs);
        end
        req_valid   = 2'b11;
        req_addr[0] = 7'd42;
        req_addr[1] = 7'd43;
        req_data[0] = 32'h42;
        req_data[1] = 32'h43;
        step();
        req_valid = 2'b00;
        checks++;
        if (wr_obs !== {1'b1, 7'd42, 32'h42, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midop_rr_reset: got %h, expected %h", wr_obs, {1'b1, 7'd42, 32'h42, 1'b0});
        end
        step();
        checks++;
        if (wr_obs !== {1'b1, 7'd43, 32'h43, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midop_second: got %h, expected %h", wr_obs, {1'b1, 7'd43, 32'h43, 1'b1});
        end
        step();
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_fairness();
        test_zero_reg();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
